frame_pixel_reader: RTL and testbench

- Read side of the video effect path: consumes the 3-bit display mode from the mode controller and the VGA timing pixel requests.
- Generates frame-buffer read addresses, applying zoom by coordinate replication.
- Applies the colour effect (channel isolate or greyscale) to returned data and presents one RGB888 pixel per request with fixed latency.
- Sits between the frame buffer RAM read port and the VGA output stage.

---
 rtl/frame_pixel_reader.sv | 194 +++++++++++++++++++
 tb/tb_frame_pixel_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_reader.sv
`default_nettype none
// ============================================================================
//  frame_pixel_reader
//  Frame-buffer read side: zoomed address generation and colour effects.
//  Revision: 1.0
// ============================================================================
module frame_pixel_reader #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int MEM_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [23:0]       mem_rdata,
    output logic [23:0]       pix_out,
    output logic              pix_valid
);

    localparam int c_XW = $clog2(H_ACTIVE);
    localparam int c_YW = $clog2(V_ACTIVE);

    localparam logic [c_XW-1:0]   c_X_LAST = c_XW'(H_ACTIVE - 1);
    localparam logic [c_YW-1:0]   c_Y_LAST = c_YW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(H_ACTIVE);

    localparam logic [2:0] c_MODE_NORMAL = 3'b000;
    localparam logic [2:0] c_MODE_RED    = 3'b001;
    localparam logic [2:0] c_MODE_GREEN  = 3'b010;
    localparam logic [2:0] c_MODE_BLUE   = 3'b011;
    localparam logic [2:0] c_MODE_GSCALE = 3'b100;
    localparam logic [2:0] c_MODE_ZOOM2  = 3'b101;
    localparam logic [2:0] c_MODE_ZOOM3  = 3'b110;
    localparam logic [2:0] c_MODE_ZOOM4  = 3'b111;

    // Frame-position state
    logic [2:0]        mode_q,     mode_d;
    logic [c_XW-1:0]   x_q,        x_d;
    logic [c_YW-1:0]   y_q,        y_d;
    logic [1:0]        zx_q,       zx_d;
    logic [1:0]        zy_q,       zy_d;
    logic [c_XW-1:0]   src_x_q,    src_x_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              done_q,     done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    // Read pipeline: stage 0 is the issue register, stage MEM_LAT meets mem_rdata
    logic [MEM_LAT:0]  vld_q;
    logic [2:0]        tag_q [0:MEM_LAT];
    logic [23:0]       pix_out_q;
    logic              pix_valid_q;

    // frame_start overrides the stored position so a coincident request is pixel 0
    logic [2:0]        w_cur_mode;
    logic [c_XW-1:0]   w_cur_x;
    logic [c_YW-1:0]   w_cur_y;
    logic [1:0]        w_cur_zx;
    logic [1:0]        w_cur_zy;
    logic [c_XW-1:0]   w_cur_src;
    logic [ADDR_W-1:0] w_cur_row;
    logic [1:0]        w_zmax;
    logic              w_accept;

    function automatic logic [23:0] apply_effect(input logic [2:0] m, input logic [23:0] d);
        logic [9:0] s;
        logic [7:0] y;
        s = {2'b00, d[23:16]} + {1'b0, d[15:8], 1'b0} + {2'b00, d[7:0]};
        y = 8'(s >> 2);
        case (m)
            c_MODE_RED:    apply_effect = {d[23:16], 16'h0000};
            c_MODE_GREEN:  apply_effect = {8'h00, d[15:8], 8'h00};
            c_MODE_BLUE:   apply_effect = {16'h0000, d[7:0]};
            c_MODE_GSCALE: apply_effect = {y, y, y};
            default:       apply_effect = d;
        endcase
    endfunction

    always_comb begin
        w_cur_mode = frame_start ? state : mode_q;
        w_cur_x    = frame_start ? '0 : x_q;
        w_cur_y    = frame_start ? '0 : y_q;
        w_cur_zx   = frame_start ? '0 : zx_q;
        w_cur_zy   = frame_start ? '0 : zy_q;
        w_cur_src  = frame_start ? '0 : src_x_q;
        w_cur_row  = frame_start ? '0 : row_base_q;
        w_accept   = pix_req && (frame_start || !done_q);

        case (w_cur_mode)
            c_MODE_ZOOM2: w_zmax = 2'd1;
            c_MODE_ZOOM3: w_zmax = 2'd2;
            c_MODE_ZOOM4: w_zmax = 2'd3;
            default:      w_zmax = 2'd0;
        endcase

        mode_d     = w_cur_mode;
        x_d        = w_cur_x;
        y_d        = w_cur_y;
        zx_d       = w_cur_zx;
        zy_d       = w_cur_zy;
        src_x_d    = w_cur_src;
        row_base_d = w_cur_row;
        done_d     = frame_start ? 1'b0 : done_q;
        mem_addr_d = mem_addr_q;

        if (w_accept) begin
            mem_addr_d = w_cur_row + ADDR_W'(w_cur_src);
            if (w_cur_x == c_X_LAST) begin
                x_d     = '0;
                zx_d    = '0;
                src_x_d = '0;
                if (w_cur_y == c_Y_LAST) begin
                    y_d        = '0;
                    zy_d       = '0;
                    row_base_d = '0;
                    done_d     = 1'b1;
                end else begin
                    y_d = w_cur_y + c_YW'(1);
                    if (w_cur_zy == w_zmax) begin
                        zy_d       = '0;
                        row_base_d = w_cur_row + c_STRIDE;
                    end else begin
                        zy_d = w_cur_zy + 2'd1;
                    end
                end
            end else begin
                x_d = w_cur_x + c_XW'(1);
                if (w_cur_zx == w_zmax) begin
                    zx_d    = '0;
                    src_x_d = w_cur_src + c_XW'(1);
                end else begin
                    zx_d = w_cur_zx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= c_MODE_NORMAL;
            x_q        <= '0;
            y_q        <= '0;
            zx_q       <= '0;
            zy_q       <= '0;
            src_x_q    <= '0;
            row_base_q <= '0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mode_q     <= mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
            zx_q       <= zx_d;
            zy_q       <= zy_d;
            src_x_q    <= src_x_d;
            row_base_q <= row_base_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // The mode tag rides with each read so effects stay fixed for the whole frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            for (int i = 0; i <= MEM_LAT; i++) begin
                tag_q[i] <= c_MODE_NORMAL;
            end
        end else begin
            vld_q    <= {vld_q[MEM_LAT-1:0], w_accept};
            tag_q[0] <= w_cur_mode;
            for (int i = 1; i <= MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            pix_valid_q <= vld_q[MEM_LAT];
            if (vld_q[MEM_LAT]) begin
                pix_out_q <= apply_effect(tag_q[MEM_LAT], mem_rdata);
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = vld_q[0];
    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_pixel_reader.sv
`default_nettype none
// Testbench for frame_pixel_reader: full-size instance plus a tiny-frame instance
// for end-of-frame behaviour, both checked against an arithmetic reference model.
module tb_frame_pixel_reader;

    localparam int H = 640, V = 480, AW = 19, LAT = 2;
    localparam int SH = 8, SV = 4, SAW = 5, SLAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, frame_start, pix_req;
    logic [2:0]     state;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd, pix_valid;
    logic [23:0]    mem_rdata, pix_out;

    logic           s_fs, s_req;
    logic [2:0]     s_state;
    logic [SAW-1:0] s_mem_addr;
    logic           s_mem_rd, s_pix_valid;
    logic [23:0]    s_mem_rdata, s_pix_out;

    frame_pixel_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .frame_start(frame_start), .pix_req(pix_req),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .pix_out(pix_out), .pix_valid(pix_valid));

    frame_pixel_reader #(.H_ACTIVE(SH), .V_ACTIVE(SV), .ADDR_W(SAW), .MEM_LAT(SLAT)) dut_s (
        .clk(clk), .rst_n(rst_n), .state(s_state), .frame_start(s_fs), .pix_req(s_req),
        .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_rdata(s_mem_rdata),
        .pix_out(s_pix_out), .pix_valid(s_pix_valid));

    int errors = 0, checks = 0, cyc = 0;
    bit use_const = 1'b0;
    logic [23:0] const_data = 24'h0;

    function automatic logic [23:0] ram_val(input int a);
        logic [31:0] t;
        if (use_const) return const_data;
        t = 32'(a + 7) * 32'h9E3779B1;
        return t[31:8];
    endfunction

    function automatic int exp_addr(input int k, input int mode, input int h);
        int z = (mode >= 5) ? mode - 3 : 1;
        return ((k / h) / z) * h + (k % h) / z;
    endfunction

    function automatic logic [23:0] exp_effect(input logic [23:0] d, input int mode);
        int s;
        logic [7:0] y;
        s = int'(d[23:16]) + 2 * int'(d[15:8]) + int'(d[7:0]);
        y = 8'(s / 4);
        case (mode)
            1: return {d[23:16], 16'h0};
            2: return {8'h0, d[15:8], 8'h0};
            3: return {16'h0, d[7:0]};
            4: return {y, y, y};
            default: return d;
        endcase
    endfunction

    // Frame-buffer models with fixed read latency
    logic [23:0] pipe  [0:LAT-1];
    logic [23:0] spipe [0:SLAT-1];
    always @(posedge clk) begin
        pipe[0]  <= mem_rd   ? ram_val(int'(mem_addr))   : 24'hDEAD00;
        spipe[0] <= s_mem_rd ? ram_val(int'(s_mem_addr)) : 24'hDEAD00;
        for (int i = 1; i < LAT; i++)  pipe[i]  <= pipe[i-1];
        for (int i = 1; i < SLAT; i++) spipe[i] <= spipe[i-1];
    end
    assign mem_rdata   = pipe[LAT-1];
    assign s_mem_rdata = spipe[SLAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    int rd_addr[$], rd_cyc[$], out_cyc[$], s_rd_addr[$];
    logic [23:0] out_pix[$], s_out_pix[$];
    always @(posedge clk) begin
        #1;
        if (mem_rd === 1'b1)      begin rd_addr.push_back(int'(mem_addr)); rd_cyc.push_back(cyc); end
        if (pix_valid === 1'b1)   begin out_pix.push_back(pix_out); out_cyc.push_back(cyc); end
        if (s_mem_rd === 1'b1)    s_rd_addr.push_back(int'(s_mem_addr));
        if (s_pix_valid === 1'b1) s_out_pix.push_back(s_pix_out);
    end

    task automatic clr();
        rd_addr.delete(); rd_cyc.delete(); out_pix.delete(); out_cyc.delete();
        s_rd_addr.delete(); s_out_pix.delete();
    endtask

    task automatic tick(input bit fs, input bit req, input logic [2:0] st);
        @(negedge clk);
        frame_start = fs; pix_req = req; state = st;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, state);
    endtask

    task automatic run_frame(input logic [2:0] md, input int n, input bit gaps, input bit noise);
        int issued;
        bit req;
        tick(1'b1, 1'b1, md);
        issued = 1;
        while (issued < n) begin
            req = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick(1'b0, req, noise ? 3'($urandom_range(0, 7)) : md);
            if (req) issued++;
        end
        idle(LAT + 4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; pix_req = 1'b0; state = 3'd0;
        s_fs = 1'b0; s_req = 1'b0; s_state = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
        checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL reset_rd: got %b expected 0", mem_rd); end
        checks++; if (pix_out !== 24'h0)  begin errors++; $display("FAIL reset_pix: got %h expected 0", pix_out); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
        checks++; if (s_mem_rd !== 1'b0 || s_pix_valid !== 1'b0)
            begin errors++; $display("FAIL reset_small: got rd=%b valid=%b expected 0/0", s_mem_rd, s_pix_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int e0;
        clr();
        tick(1'b1, 1'b1, 3'd0);
        e0 = cyc + 1;
        repeat (3) tick(1'b0, 1'b1, 3'd0);
        idle(LAT + 6);
        checks++; if (rd_addr.size() !== 4) begin errors++; $display("FAIL basic_rd_count: got %0d expected 4", rd_addr.size()); end
        for (int i = 0; i < rd_addr.size() && i < 4; i++) begin
            checks++; if (rd_addr[i] !== i) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, rd_addr[i], i); end
            checks++; if (rd_cyc[i] !== e0 + i) begin errors++; $display("FAIL basic_rd_time[%0d]: got %0d expected %0d", i, rd_cyc[i], e0 + i); end
        end
        checks++; if (out_pix.size() !== 4) begin errors++; $display("FAIL basic_out_count: got %0d expected 4", out_pix.size()); end
        for (int i = 0; i < out_pix.size() && i < 4; i++) begin
            checks++; if (out_cyc[i] !== e0 + LAT + 1 + i)
                begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, out_cyc[i], e0 + LAT + 1 + i); end
            checks++; if (out_pix[i] !== exp_effect(ram_val(i), 0))
                begin errors++; $display("FAIL basic_pix[%0d]: got %h expected %h", i, out_pix[i], exp_effect(ram_val(i), 0)); end
        end
    endtask

    task automatic test_zoom(input logic [2:0] md, input int n, input int i_a, input int v_a,
                             input int i_b, input int v_b);
        clr();
        run_frame(md, n, 1'b0, 1'b0);
        checks++; if (rd_addr.size() !== n) begin errors++; $display("FAIL zoom%0d_count: got %0d expected %0d", md, rd_addr.size(), n); end
        if (rd_addr.size() == n) begin
            checks++; if (rd_addr[i_a] !== v_a) begin errors++; $display("FAIL zoom%0d_addr[%0d]: got %0d expected %0d", md, i_a, rd_addr[i_a], v_a); end
            checks++; if (rd_addr[i_b] !== v_b) begin errors++; $display("FAIL zoom%0d_addr[%0d]: got %0d expected %0d", md, i_b, rd_addr[i_b], v_b); end
            checks++; if (rd_addr[H] !== 0) begin errors++; $display("FAIL zoom%0d_line1: got %0d expected 0", md, rd_addr[H]); end
            checks++; if (rd_cyc[n-1] - rd_cyc[0] !== n - 1)
                begin errors++; $display("FAIL zoom%0d_b2b: got %0d expected %0d", md, rd_cyc[n-1] - rd_cyc[0], n - 1); end
        end
        for (int i = 0; i < rd_addr.size(); i++) begin
            checks++; if (rd_addr[i] !== exp_addr(i, md, H))
                begin errors++; $display("FAIL zoom%0d_seq[%0d]: got %0d expected %0d", md, i, rd_addr[i], exp_addr(i, md, H)); end
        end
        checks++; if (out_pix.size() !== n) begin errors++; $display("FAIL zoom%0d_out_count: got %0d expected %0d", md, out_pix.size(), n); end
        for (int i = 0; i < out_pix.size(); i++) begin
            checks++; if (out_pix[i] !== ram_val(exp_addr(i, md, H)))
                begin errors++; $display("FAIL zoom%0d_pix[%0d]: got %h expected %h", md, i, out_pix[i], ram_val(exp_addr(i, md, H))); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [2:0] md;
            int n;
            md = 3'($urandom_range(0, 7));
            n  = $urandom_range(500, 1300);
            clr();
            run_frame(md, n, 1'b1, 1'b1);
            checks++; if (rd_addr.size() !== n) begin errors++; $display("FAIL rand_count: got %0d expected %0d", rd_addr.size(), n); end
            for (int i = 0; i < rd_addr.size(); i++) begin
                checks++; if (rd_addr[i] !== exp_addr(i, md, H))
                    begin errors++; $display("FAIL rand_addr[%0d] mode %0d: got %0d expected %0d", i, md, rd_addr[i], exp_addr(i, md, H)); end
            end
            checks++; if (out_pix.size() !== n) begin errors++; $display("FAIL rand_out_count: got %0d expected %0d", out_pix.size(), n); end
            for (int i = 0; i < out_pix.size(); i++) begin
                checks++; if (out_pix[i] !== exp_effect(ram_val(exp_addr(i, md, H)), md))
                    begin errors++; $display("FAIL rand_pix[%0d] mode %0d: got %h expected %h", i, md, out_pix[i],
                                             exp_effect(ram_val(exp_addr(i, md, H)), md)); end
            end
        end
    endtask

    task automatic test_gscale();
        clr();
        use_const = 1'b1; const_data = 24'hFF8000;
        tick(1'b1, 1'b1, 3'd4);
        idle(LAT + 3);
        const_data = 24'hFFFFFF;
        tick(1'b0, 1'b1, 3'd4);
        idle(LAT + 3);
        use_const = 1'b0;
        checks++; if (out_pix.size() !== 2) begin errors++; $display("FAIL gscale_count: got %0d expected 2", out_pix.size()); end
        if (out_pix.size() == 2) begin
            checks++; if (out_pix[0] !== 24'h7F7F7F) begin errors++; $display("FAIL gscale_mid: got %h expected 7f7f7f", out_pix[0]); end
            checks++; if (out_pix[1] !== 24'hFFFFFF) begin errors++; $display("FAIL gscale_max: got %h expected ffffff", out_pix[1]); end
        end
    endtask

    task automatic test_mode_latch();
        clr();
        tick(1'b1, 1'b1, 3'd0);
        tick(1'b0, 1'b1, 3'd1);
        tick(1'b0, 1'b1, 3'd1);
        idle(LAT + 3);
        use_const = 1'b1; const_data = 24'h123456;
        tick(1'b1, 1'b1, 3'd1);
        idle(LAT + 3);
        use_const = 1'b0;
        checks++; if (out_pix.size() !== 4) begin errors++; $display("FAIL latch_count: got %0d expected 4", out_pix.size()); end
        if (out_pix.size() == 4 && rd_addr.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (out_pix[i] !== ram_val(i)) begin errors++; $display("FAIL latch_pass[%0d]: got %h expected %h", i, out_pix[i], ram_val(i)); end
            end
            checks++; if (rd_addr[3] !== 0) begin errors++; $display("FAIL latch_restart_addr: got %0d expected 0", rd_addr[3]); end
            checks++; if (out_pix[3] !== 24'h120000) begin errors++; $display("FAIL latch_red: got %h expected 120000", out_pix[3]); end
        end
    endtask

    task automatic test_reset_inflight();
        clr();
        tick(1'b1, 1'b1, 3'd2);
        tick(1'b0, 1'b1, 3'd2);
        tick(1'b0, 1'b1, 3'd2);
        @(negedge clk); pix_req = 1'b0; frame_start = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_rd !== 1'b0 || pix_valid !== 1'b0)
            begin errors++; $display("FAIL rst_strobes: got rd=%b valid=%b expected 0/0", mem_rd, pix_valid); end
        idle(LAT + 4);
        checks++; if (out_pix.size() !== 0) begin errors++; $display("FAIL rst_discard: got %0d outputs expected 0", out_pix.size()); end
        checks++; if (rd_addr.size() !== 3) begin errors++; $display("FAIL rst_issued: got %0d reads expected 3", rd_addr.size()); end
        // After reset: counters at zero, mode NORMAL regardless of state input
        clr();
        tick(1'b0, 1'b1, 3'd3);
        tick(1'b0, 1'b1, 3'd3);
        tick(1'b1, 1'b1, 3'd0);
        idle(LAT + 4);
        checks++; if (rd_addr.size() !== 3) begin errors++; $display("FAIL post_rst_count: got %0d expected 3", rd_addr.size()); end
        checks++; if (out_pix.size() !== 3) begin errors++; $display("FAIL post_rst_out_count: got %0d expected 3", out_pix.size()); end
        if (rd_addr.size() == 3 && out_pix.size() == 3) begin
            checks++; if (rd_addr[0] !== 0 || rd_addr[1] !== 1 || rd_addr[2] !== 0)
                begin errors++; $display("FAIL post_rst_addr: got %0d,%0d,%0d expected 0,1,0", rd_addr[0], rd_addr[1], rd_addr[2]); end
            checks++; if (out_pix[0] !== ram_val(0) || out_pix[1] !== ram_val(1) || out_pix[2] !== ram_val(0))
                begin errors++; $display("FAIL post_rst_pix: got %h,%h,%h expected %h,%h,%h", out_pix[0], out_pix[1], out_pix[2],
                                         ram_val(0), ram_val(1), ram_val(0)); end
        end
    endtask

    task automatic test_frame_end();
        int n;
        clr();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            s_fs = (c == 0) || (c == 37);
            s_req = 1'b1;
            s_state = (c < 37) ? 3'd5 : 3'd3;
        end
        @(negedge clk); s_fs = 1'b0; s_req = 1'b0;
        repeat (SLAT + 4) @(negedge clk);
        n = SH * SV + 3;
        checks++; if (s_rd_addr.size() !== n) begin errors++; $display("FAIL end_rd_count: got %0d expected %0d", s_rd_addr.size(), n); end
        checks++; if (s_out_pix.size() !== n) begin errors++; $display("FAIL end_out_count: got %0d expected %0d", s_out_pix.size(), n); end
        for (int i = 0; i < s_rd_addr.size() && i < n && i < s_out_pix.size(); i++) begin
            int md, k, ea;
            md = (i < SH * SV) ? 5 : 3;
            k  = (i < SH * SV) ? i : i - SH * SV;
            ea = exp_addr(k, md, SH);
            checks++; if (s_rd_addr[i] !== ea) begin errors++; $display("FAIL end_addr[%0d]: got %0d expected %0d", i, s_rd_addr[i], ea); end
            checks++; if (s_out_pix[i] !== exp_effect(ram_val(ea), md))
                begin errors++; $display("FAIL end_pix[%0d]: got %h expected %h", i, s_out_pix[i], exp_effect(ram_val(ea), md)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zoom(3'd5, 2 * H + 1, 639, 319, 2 * H, 640);
        test_zoom(3'd6, 3 * H + 1, 639, 213, 3 * H, 640);
        test_gscale();
        test_mode_latch();
        test_random();
        test_reset_inflight();
        test_frame_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
